// File: rtl/mvu_xbar_if.sv
// Handshake bundle between the MVU senders/receivers and the crossbar.
// slave  : crossbar view (takes sender words, presents receiver FIFO heads)
// master : environment view (drives sender words and receiver ready)
interface mvu_xbar_if #(
  parameter int NMVU  = 8,
  parameter int BW    = 64,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [NMVU-1:0]      send_en;
  logic [NMVU*BW-1:0]   send_word;
  logic [NMVU-1:0]      send_rdy;
  logic [NMVU-1:0]      recv_en;
  logic [NMVU*BW-1:0]   recv_word;
  logic [NMVU-1:0]      recv_rdy;
  logic [NMVU*CW-1:0]   recv_cnt;

  modport slave (
    input  send_en, send_word, recv_rdy,
    output send_rdy, recv_en, recv_word, recv_cnt
  );

  modport master (
    output send_en, send_word, recv_rdy,
    input  send_rdy, recv_en, recv_word, recv_cnt
  );
endinterface

// File: rtl/mvu_xbar.sv
// Buffered MVU crossbar: each receiver selects one sender, owns a small FIFO,
// and a sender is only accepted when every enabled subscriber has room, so a
// multicast word lands in all subscriber FIFOs or in none.
module mvu_xbar #(
  parameter  int NMVU  = 8,
  parameter  int BW    = 64,
  parameter  int DEPTH = 4,
  localparam int BMVUA = $clog2(NMVU)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ic_clr,
  input  logic [NMVU-1:0]       cfg_we,
  input  logic [NMVU*BMVUA-1:0] cfg_from,
  input  logic [NMVU-1:0]       cfg_en,
  mvu_xbar_if.slave             xb
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [BMVUA-1:0] r_src  [NMVU];
  logic [NMVU-1:0]  r_en;
  logic [BW-1:0]    r_mem  [NMVU][DEPTH];
  logic [PW-1:0]    r_wptr [NMVU];
  logic [PW-1:0]    r_rptr [NMVU];
  logic [CW-1:0]    r_cnt  [NMVU];

  logic [BW-1:0]      w_sword [NMVU];
  logic [NMVU-1:0]    w_rdy;
  logic [NMVU-1:0]    w_push;
  logic [NMVU-1:0]    w_pop;
  logic [NMVU-1:0]    w_recv_en;
  logic [NMVU*BW-1:0] w_recv_word;
  logic [NMVU*CW-1:0] w_recv_cnt;

  // Unpack the flat sender word bus so receivers can index it by source.
  always_comb begin
    for (int s = 0; s < NMVU; s++) begin
      w_sword[s] = xb.send_word[s*BW +: BW];
    end
  end

  // Sender ready: low if any enabled subscriber FIFO is full. Built from
  // registered state only, so no input handshake reaches send_rdy.
  always_comb begin
    w_rdy = '1;
    for (int s = 0; s < NMVU; s++) begin
      for (int r = 0; r < NMVU; r++) begin
        if (r_en[r] && (r_src[r] == BMVUA'(s)) && (r_cnt[r] == CW'(DEPTH))) begin
          w_rdy[s] = 1'b0;
        end
      end
    end
  end

  // Per-receiver push (accepted word from its source) and pop (head consumed).
  always_comb begin
    w_push = '0;
    w_pop  = '0;
    for (int r = 0; r < NMVU; r++) begin
      w_push[r] = r_en[r] & xb.send_en[r_src[r]] & w_rdy[r_src[r]];
      w_pop[r]  = (r_cnt[r] != '0) & xb.recv_rdy[r];
    end
  end

  // Routing registers; a clear wins over any write in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_en <= '0;
      for (int r = 0; r < NMVU; r++) r_src[r] <= '0;
    end else if (ic_clr) begin
      r_en <= '0;
      for (int r = 0; r < NMVU; r++) r_src[r] <= '0;
    end else begin
      for (int r = 0; r < NMVU; r++) begin
        if (cfg_we[r]) begin
          r_src[r] <= cfg_from[r*BMVUA +: BMVUA];
          r_en[r]  <= cfg_en[r];
        end
      end
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NMVU; r++) begin
        r_wptr[r] <= '0;
        r_rptr[r] <= '0;
        r_cnt[r]  <= '0;
      end
    end else if (ic_clr) begin
      for (int r = 0; r < NMVU; r++) begin
        r_wptr[r] <= '0;
        r_rptr[r] <= '0;
        r_cnt[r]  <= '0;
      end
    end else begin
      for (int r = 0; r < NMVU; r++) begin
        if (w_push[r]) r_wptr[r] <= r_wptr[r] + PW'(1);
        if (w_pop[r])  r_rptr[r] <= r_rptr[r] + PW'(1);
        if (w_push[r] && !w_pop[r]) begin
          r_cnt[r] <= r_cnt[r] + CW'(1);
        end else if (!w_push[r] && w_pop[r]) begin
          r_cnt[r] <= r_cnt[r] - CW'(1);
        end
      end
    end
  end

  // FIFO storage; contents need no reset because the head is masked when empty.
  always_ff @(posedge clk) begin
    for (int r = 0; r < NMVU; r++) begin
      if (w_push[r] && !ic_clr) begin
        r_mem[r][r_wptr[r]] <= w_sword[r_src[r]];
      end
    end
  end

  // Receiver outputs: head word, valid and occupancy, all from registers.
  always_comb begin
    w_recv_en   = '0;
    w_recv_word = '0;
    w_recv_cnt  = '0;
    for (int r = 0; r < NMVU; r++) begin
      w_recv_en[r]              = (r_cnt[r] != '0);
      w_recv_cnt[r*CW +: CW]    = r_cnt[r];
      if (r_cnt[r] != '0) begin
        w_recv_word[r*BW +: BW] = r_mem[r][r_rptr[r]];
      end
    end
  end

  assign xb.send_rdy  = w_rdy;
  assign xb.recv_en   = w_recv_en;
  assign xb.recv_word = w_recv_word;
  assign xb.recv_cnt  = w_recv_cnt;

endmodule

// File: tb/tb_mvu_xbar.sv
// Bench for mvu_xbar: a per-receiver queue model holds the words expected in
// each FIFO; words are queued when a sender transfer is accepted and compared
// against the DUT FIFO head when the receiver pops.
module tb_mvu_xbar;
  localparam int N  = 8;
  localparam int BW = 64;
  localparam int D  = 4;
  localparam int BA = 3;
  localparam int CW = 3;

  logic          clk      = 1'b0;
  logic          rst_n    = 1'b0;
  logic          ic_clr   = 1'b0;
  logic [N-1:0]  cfg_we   = '0;
  logic [N-1:0]  cfg_en   = '0;
  logic [N*BA-1:0] cfg_from = '0;

  int n_chk = 0;
  int n_bad = 0;
  int acc4  = 0;

  logic [BW-1:0] q [N][$];
  int            m_src [N];
  bit            m_en  [N];

  mvu_xbar_if #(.NMVU(N), .BW(BW), .DEPTH(D)) xb ();

  mvu_xbar #(.NMVU(N), .BW(BW), .DEPTH(D)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ic_clr   (ic_clr),
    .cfg_we   (cfg_we),
    .cfg_from (cfg_from),
    .cfg_en   (cfg_en),
    .xb       (xb)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clr();
    for (int r = 0; r < N; r++) begin
      q[r].delete();
      m_en[r]  = 1'b0;
      m_src[r] = 0;
    end
  endtask

  // One clock cycle: called at the falling edge with inputs already driven.
  task automatic cyc();
    logic [N-1:0] rdy_e;
    logic [N-1:0] xfer;
    #1;
    for (int s = 0; s < N; s++) begin
      rdy_e[s] = 1'b1;
      for (int r = 0; r < N; r++) begin
        if (m_en[r] && m_src[r] == s && q[r].size() >= D) rdy_e[s] = 1'b0;
      end
    end
    chk("send_rdy", 64'(xb.send_rdy), 64'(rdy_e));
    for (int r = 0; r < N; r++) begin
      chk($sformatf("recv_en%0d", r), 64'(xb.recv_en[r]), 64'(q[r].size() != 0));
      chk($sformatf("recv_cnt%0d", r), 64'(xb.recv_cnt[r*CW +: CW]), 64'(q[r].size()));
      if (q[r].size() != 0) begin
        chk($sformatf("recv_word%0d", r), xb.recv_word[r*BW +: BW], q[r][0]);
      end
    end
    if (xb.send_rdy[4] && xb.send_en[4]) acc4++;
    xfer = xb.send_en & rdy_e;
    if (ic_clr) begin
      model_clr();
    end else begin
      for (int r = 0; r < N; r++) begin
        if (xb.recv_rdy[r] && q[r].size() != 0) void'(q[r].pop_front());
      end
      for (int s = 0; s < N; s++) begin
        if (xfer[s]) begin
          for (int r = 0; r < N; r++) begin
            if (m_en[r] && m_src[r] == s) q[r].push_back(xb.send_word[s*BW +: BW]);
          end
        end
      end
      for (int r = 0; r < N; r++) begin
        if (cfg_we[r]) begin
          m_src[r] = int'(cfg_from[r*BA +: BA]);
          m_en[r]  = cfg_en[r];
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < N; s++) begin
      if (xfer[s]) xb.send_word[s*BW +: BW] = xb.send_word[s*BW +: BW] + 64'd1;
    end
  endtask

  task automatic cfg(input logic [N-1:0] we, input int src, input bit en);
    cfg_we = we;
    for (int r = 0; r < N; r++) begin
      if (we[r]) begin
        cfg_from[r*BA +: BA] = BA'(src);
        cfg_en[r]            = en;
      end
    end
    cyc();
    cfg_we = '0;
  endtask

  initial begin
    xb.send_en  = '0;
    xb.recv_rdy = '0;
    for (int s = 0; s < N; s++) xb.send_word[s*BW +: BW] = {8'(s + 1), 56'h0};
    model_clr();

    // reset values
    #12;
    chk("rst_send_rdy", 64'(xb.send_rdy), 64'hFF);
    chk("rst_recv_en", 64'(xb.recv_en), 64'h0);
    chk("rst_recv_cnt", 64'(xb.recv_cnt), 64'h0);
    for (int r = 0; r < N; r++) chk("rst_recv_word", xb.recv_word[r*BW +: BW], 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();

    // unicast r1 <- s0
    cfg(8'h02, 0, 1'b1);
    xb.recv_rdy[1] = 1'b1;
    xb.send_en[0]  = 1'b1;
    xb.send_word[0 +: BW] = 64'hA5A5_A5A5_A5A5_A5A5;
    cyc();
    xb.send_word[0 +: BW] = 64'h5A5A_5A5A_5A5A_5A5A;
    cyc();
    xb.send_en[0] = 1'b0;
    repeat (3) cyc();
    cfg(8'h02, 0, 1'b0);
    xb.recv_rdy = '0;

    // multicast r2,r3 <- s4 with r3 stalled
    cfg(8'h0C, 4, 1'b1);
    xb.recv_rdy[2] = 1'b1;
    xb.send_en[4]  = 1'b1;
    acc4 = 0;
    repeat (8) cyc();
    chk("mc_accepted", 64'(acc4), 64'(D));
    xb.send_en[4]  = 1'b0;
    xb.recv_rdy[3] = 1'b1;
    repeat (6) cyc();
    cfg(8'h0C, 0, 1'b0);
    xb.recv_rdy = '0;

    // full FIFO with simultaneous pop, r0 <- s3
    cfg(8'h01, 3, 1'b1);
    xb.send_en[3] = 1'b1;
    repeat (5) cyc();
    xb.recv_rdy[0] = 1'b1;
    repeat (8) cyc();
    xb.send_en[3] = 1'b0;
    repeat (5) cyc();
    cfg(8'h01, 0, 1'b0);
    xb.recv_rdy = '0;

    // reroute r5 from s1 to s2 with words buffered
    cfg(8'h20, 1, 1'b1);
    xb.send_en[1] = 1'b1;
    repeat (2) cyc();
    xb.send_en[1] = 1'b0;
    cfg(8'h20, 2, 1'b1);
    xb.send_en[1] = 1'b1;
    xb.send_en[2] = 1'b1;
    repeat (2) cyc();
    xb.send_en = '0;
    xb.recv_rdy[5] = 1'b1;
    repeat (5) cyc();
    xb.recv_rdy = '0;
    cfg(8'h20, 0, 1'b0);

    // ic_clr together with cfg write, push and pop
    cfg(8'h40, 5, 1'b1);
    xb.send_en[5] = 1'b1;
    repeat (2) cyc();
    ic_clr = 1'b1;
    cfg_we = 8'h80;
    cfg_from[7*BA +: BA] = 3'd5;
    cfg_en[7] = 1'b1;
    xb.recv_rdy[6] = 1'b1;
    cyc();
    ic_clr = 1'b0;
    cfg_we = '0;
    chk("clr_recv_cnt", 64'(xb.recv_cnt), 64'h0);
    chk("clr_recv_en", 64'(xb.recv_en), 64'h0);
    chk("clr_send_rdy", 64'(xb.send_rdy), 64'hFF);
    repeat (3) cyc();
    xb.send_en  = '0;
    xb.recv_rdy = '0;

    // asynchronous reset between edges with data buffered
    cfg(8'h10, 6, 1'b1);
    xb.send_en[6] = 1'b1;
    repeat (3) cyc();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_recv_cnt", 64'(xb.recv_cnt), 64'h0);
    chk("arst_recv_en", 64'(xb.recv_en), 64'h0);
    chk("arst_send_rdy", 64'(xb.send_rdy), 64'hFF);
    chk("arst_recv_word4", xb.recv_word[4*BW +: BW], 64'h0);
    model_clr();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) cyc();
    xb.send_en = '0;

    // random mix of routing, traffic and backpressure
    for (int i = 0; i < 120; i++) begin
      xb.send_en  = N'($urandom);
      xb.recv_rdy = N'($urandom);
      cfg_we      = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
      cfg_from    = (N*BA)'($urandom);
      cfg_en      = N'($urandom);
      ic_clr      = ($urandom_range(0, 40) == 0);
      cyc();
    end
    xb.send_en  = '0;
    xb.recv_rdy = '1;
    cfg_we      = '0;
    ic_clr      = 1'b0;
    repeat (6) cyc();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
